// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control block.
// Optional overflow stop: define STOPWATCH_OVF_STOP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus registered rising-edge pulse.
// Optional overflow stop (in top): define STOPWATCH_OVF_STOP_EN.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] primed;
  logic                   hist;

  // History starts high and only tracks once the chain holds real
  // samples, so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync     <= '0;
      primed   <= '0;
      hist     <= 1'b1;
      edge_out <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], btn_in};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      if (primed[SYNC_STAGES-1]) begin
        hist     <= sync[SYNC_STAGES-1];
        edge_out <= sync[SYNC_STAGES-1] & ~hist;
      end else begin
        edge_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: buttons to counter enable/reset, lap display.
// Optional overflow stop: define STOPWATCH_OVF_STOP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          btn_start,
  input  logic                          btn_lap,
  input  logic                          btn_clear,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] cnt_valor,
  input  logic                          cnt_carry_msd,
  output logic                          cnt_enable,
  output logic                          cnt_reset,
  output logic [DIGIT_W*NUM_DIGITS-1:0] disp_valor,
  output logic [1:0]                    state,
  output logic                          ovf
);

  sw_state_t cur;
  logic      p_start;
  logic      p_lap;
  logic      p_clear;
  logic      stop;
  logic      start_ok;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_start),
    .edge_out (p_start)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_lap),
    .edge_out (p_lap)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_clear),
    .edge_out (p_clear)
  );

  assign state      = cur;
  assign cnt_enable = (cur == RUN) || (cur == LAP);

`ifdef STOPWATCH_OVF_STOP_EN
  assign stop     = cnt_carry_msd & cnt_enable;
  assign start_ok = ~ovf;
`else
  logic unused_carry;
  assign unused_carry = cnt_carry_msd;
  assign stop         = 1'b0;
  assign start_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur        <= IDLE;
      cnt_reset  <= 1'b1;
      disp_valor <= '0;
      ovf        <= 1'b0;
    end else begin
      cnt_reset <= 1'b0;
      // Frozen while in LAP; the entering edge still loads.
      if (cur != LAP) disp_valor <= cnt_valor;
      if (stop) begin
        cur <= PAUSE;
        ovf <= 1'b1;
      end else begin
        unique case (cur)
          IDLE: begin
            if (p_clear) begin
              cnt_reset <= 1'b1;
              ovf       <= 1'b0;
            end else if (p_start) begin
              cur <= RUN;
            end
          end
          RUN: begin
            if (p_start) cur <= PAUSE;
            else if (p_lap) cur <= LAP;
          end
          LAP: begin
            if (p_start) cur <= PAUSE;
            else if (p_lap) cur <= RUN;
          end
          PAUSE: begin
            if (p_clear) begin
              cur       <= IDLE;
              cnt_reset <= 1'b1;
              ovf       <= 1'b0;
            end else if (p_start && start_ok) begin
              cur <= RUN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl.
// Overflow checks enabled with STOPWATCH_OVF_STOP_EN.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] cnt_valor;
  logic        cnt_carry_msd;
  logic        cnt_enable;
  logic        cnt_reset;
  logic [15:0] disp_valor;
  logic [1:0]  state;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  stopwatch_ctrl #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start     (btn_start),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clear),
    .cnt_valor     (cnt_valor),
    .cnt_carry_msd (cnt_carry_msd),
    .cnt_enable    (cnt_enable),
    .cnt_reset     (cnt_reset),
    .disp_valor    (disp_valor),
    .state         (state),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold buttons across the 3-edge latency, then release and settle.
  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    tick(4);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    tick(3);
  endtask

  initial begin
    reset_n       = 1'b0;
    btn_start     = 1'b1;
    btn_lap       = 1'b1;
    btn_clear     = 1'b1;
    cnt_valor     = 16'h1234;
    cnt_carry_msd = 1'b0;
    tick(3);
    check("rst_state", state, S_IDLE);
    check("rst_en", cnt_enable, 1'b0);
    check("rst_creset", cnt_reset, 1'b1);
    check("rst_disp", disp_valor, 16'h0000);
    check("rst_ovf", ovf, 1'b0);

    reset_n = 1'b1;
    tick(1);
    check("rel_creset", cnt_reset, 1'b0);
    tick(6);
    check("rel_held_state", state, S_IDLE);
    check("rel_held_creset", cnt_reset, 1'b0);
    check("idle_disp_live", disp_valor, 16'h1234);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    tick(5);

    btn_start = 1'b1;
    tick(3);
    check("start_lat_pre", state, S_IDLE);
    tick(1);
    check("start_lat", state, S_RUN);
    check("run_en", cnt_enable, 1'b1);
    tick(8);
    check("start_held", state, S_RUN);
    btn_start = 1'b0;
    tick(3);

    press(1'b1, 1'b0, 1'b0);
    check("stop_state", state, S_PAUSE);
    check("stop_en", cnt_enable, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("resume_state", state, S_RUN);

    cnt_valor = 16'h0123;
    press(1'b0, 1'b1, 1'b0);
    check("lap_state", state, S_LAP);
    cnt_valor = 16'h0150;
    tick(3);
    check("lap_frozen", disp_valor, 16'h0123);
    check("lap_en", cnt_enable, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    check("unlap_state", state, S_RUN);
    check("unlap_disp", disp_valor, 16'h0150);
    cnt_valor = 16'h0160;
    #1;
    check("disp_latency", disp_valor, 16'h0150);
    tick(1);
    check("disp_track", disp_valor, 16'h0160);

    btn_clear = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("run_clear_creset", cnt_reset, 1'b0);
    end
    btn_clear = 1'b0;
    tick(3);
    check("run_clear_state", state, S_RUN);

    press(1'b0, 1'b1, 1'b0);
    check("lap2_state", state, S_LAP);
    press(1'b1, 1'b0, 1'b0);
    check("lap_to_pause", state, S_PAUSE);

    btn_clear = 1'b1;
    tick(3);
    check("pclr_pre_state", state, S_PAUSE);
    check("pclr_pre_creset", cnt_reset, 1'b0);
    tick(1);
    check("pclr_state", state, S_IDLE);
    check("pclr_creset", cnt_reset, 1'b1);
    tick(1);
    check("pclr_creset_end", cnt_reset, 1'b0);
    btn_clear = 1'b0;
    tick(3);

    btn_clear = 1'b1;
    tick(4);
    check("iclr_creset", cnt_reset, 1'b1);
    check("iclr_state", state, S_IDLE);
    btn_clear = 1'b0;
    tick(3);
    press(1'b0, 1'b1, 1'b0);
    check("idle_lap_ign", state, S_IDLE);

    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("prio_setup", state, S_PAUSE);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    tick(4);
    check("prio_sc_state", state, S_IDLE);
    check("prio_sc_creset", cnt_reset, 1'b1);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    tick(3);

    press(1'b1, 1'b0, 1'b0);
    check("prio2_setup", state, S_RUN);
    press(1'b1, 1'b1, 1'b0);
    check("prio_sl_state", state, S_PAUSE);
    press(1'b1, 1'b0, 1'b0);
    check("ovf_setup", state, S_RUN);

    cnt_carry_msd = 1'b1;
    tick(1);
    cnt_carry_msd = 1'b0;
`ifdef STOPWATCH_OVF_STOP_EN
    check("ovf_state", state, S_PAUSE);
    check("ovf_flag", ovf, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check("ovf_start_ign", state, S_PAUSE);
    check("ovf_sticky", ovf, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    check("ovf_clr_state", state, S_IDLE);
    check("ovf_clr_flag", ovf, 1'b0);
`else
    check("carry_ign_state", state, S_RUN);
    check("carry_ign_ovf", ovf, 1'b0);
    tick(3);
    check("carry_ign_en", cnt_enable, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the millisecond stopwatch's decade-counter chain.
- Turns the start/stop, lap and clear buttons into enable and reset controls for the counters.
- Supplies a display bus that follows the counters live or shows a frozen lap value.
- Sits between board buttons/digit counters and the 7-segment display driver; runs on the 1 kHz counter clock.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the counter chain and display bus.
- SYNC_STAGES, 2, flip-flop stages of the button synchronizer (min 2).

Ports:
- clk  in  1  1 kHz system clock, shared with the counter chain.
- reset_n  in  1  synchronous, active-low reset.
- btn_start  in  1  raw start/stop button, active-high level.
- btn_lap  in  1  raw lap button, active-high level.
- btn_clear  in  1  raw clear button, active-high level.
- cnt_valor  in  4*NUM_DIGITS  BCD digits from the counter chain; digit 0 in [3:0].
- cnt_carry_msd  in  1  carry pulse from the most-significant digit counter.
- cnt_enable  out  1  enable to the units counter.
- cnt_reset  out  1  active-high reset to all digit counters.
- disp_valor  out  4*NUM_DIGITS  digits to the display driver.
- state  out  2  current FSM state encoding.
- ovf  out  1  sticky overflow flag.

Behaviour:
- All flops are updated only on posedge clk. reset_n low for one edge forces:
  - state = IDLE
  - cnt_enable = 0
  - cnt_reset = 1 while reset_n is sampled low
  - disp_valor = 0
  - ovf = 0
  - synchronizer and edge history cleared
- Button path:
  - Each button passes through SYNC_STAGES flops and a rising-edge detector.
  - The edge pulse is 1 cycle wide and is asserted SYNC_STAGES+1 edges after the first edge that samples the raw input high.
  - A held button produces exactly one pulse. No debounce; buttons are debounced on the board.
- FSM states and encoding: IDLE=00, RUN=01, PAUSE=10, LAP=11.
  - IDLE: start -> RUN. clear -> stay in IDLE and pulse cnt_reset. lap ignored.
  - RUN: start -> PAUSE. lap -> LAP. clear ignored.
  - LAP: lap -> RUN. start -> PAUSE. clear ignored.
  - PAUSE: start -> RUN. clear -> IDLE and pulse cnt_reset. lap ignored.
- Simultaneous edge pulses: clear > start > lap. Only the highest-priority pulse valid in the current state acts; all others are dropped.
- cnt_enable = 1 exactly when state is RUN or LAP. It is decoded from the state register (Moore), so the first enabled edge is the edge after the transition.
- cnt_reset: registered 1-cycle pulse on the edge that performs a clear transition, plus the reset_n condition above.
- disp_valor:
  - Outside LAP: register loads cnt_valor every edge (1-cycle display latency).
  - Entering LAP: the register loads cnt_valor on the transition edge, then holds.
  - Leaving LAP: live loading resumes on the next edge.
- Clear while in LAP or RUN is ignored; the counters cannot be cleared while running.
- Without the optional feature, cnt_carry_msd is ignored and ovf is tied to 0. On counter wrap, counting continues from 0.

Optional Feature:
- Macro: STOPWATCH_OVF_STOP_EN.
- When defined:
  - cnt_carry_msd=1 while in RUN or LAP forces state to PAUSE on that edge, with priority above all buttons.
  - The same edge sets ovf=1.
  - ovf is sticky and clears only on a clear transition or reset.
  - While ovf=1, start is ignored in PAUSE.
- When undefined: behaviour is as stated in the last Behaviour bullet.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] sw_state_t {IDLE, RUN, PAUSE, LAP}
  - localparam DIGIT_W = 4
- Sub-module btn_sync_edge: parameter SYNC_STAGES; ports clk, reset_n, btn_in, edge_out. Instantiated 3 times.
- Counter chain instances stay outside this block.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with buttons high -> state=00, cnt_enable=0, cnt_reset=1 during reset, disp_valor=0. Release with buttons still high -> no edge pulses, state stays 00.
- Start/stop: from IDLE, raise btn_start at edge t and hold 10 cycles -> state=01 after edge t+3, single transition. Release and press again -> state=10, cnt_enable=0.
- Lap freeze: in RUN with cnt_valor=16'h0123, press lap -> state=11, disp_valor holds 16'h0123 while cnt_valor advances to 16'h0150. Press lap again -> disp_valor tracks cnt_valor one cycle late.
- Clear gating: clear in RUN -> ignored, cnt_reset stays 0. Clear in PAUSE -> one-cycle cnt_reset=1, state=00.
- Priority: pulse start and clear on the same cycle in PAUSE -> IDLE with cnt_reset pulse. Pulse start and lap together in RUN -> PAUSE.
- STOPWATCH_OVF_STOP_EN: in RUN, pulse cnt_carry_msd -> state=10 and ovf=1 next edge. Start is then ignored. Clear -> ovf=0, state=00.
